// File: rtl/irq_vector_sequencer_pkg.sv
// Shared definitions for the 6502 interrupt/vector sequencer: states, entry kinds,
// fixed vector addresses and status-register bit positions.
package irq_vector_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RST_START,
    PUSH_PCH,
    PUSH_PCL,
    PUSH_P,
    VEC_LO,
    VEC_HI,
    LOAD
  } seq_state_e;

  typedef enum logic [1:0] {
    KIND_RST,
    KIND_NMI,
    KIND_BRK,
    KIND_IRQ
  } entry_kind_e;

  localparam logic [15:0] VEC_NMI   = 16'hFFFA;
  localparam logic [15:0] VEC_RESET = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ   = 16'hFFFE;

  localparam int P_I = 2;
  localparam int P_B = 4;
  localparam int P_U = 5;

  // Status byte as it lands on the stack: U always set, B marks a software break.
  function automatic logic [7:0] push_status(input logic [7:0] p, input logic is_brk);
    logic [7:0] r;
    r      = p;
    r[P_U] = 1'b1;
    r[P_B] = is_brk;
    return r;
  endfunction

endpackage

// File: rtl/irq_vector_sequencer_irq_prio_enc.sv
// Masked fixed-priority encoder: lowest set index wins, reported as valid,
// binary index and one-hot.
module irq_prio_enc #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o,
  output logic [N-1:0]     onehot_o
);

  always_comb begin
    valid_o  = 1'b0;
    idx_o    = '0;
    onehot_o = '0;
    // Scan downward so the lowest requesting index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o     = 1'b1;
        idx_o       = IDX_W'(i);
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_vector_sequencer.sv
// Owns the bus during RESET/NMI/BRK/IRQ entry: pushes PC and P, fetches the
// vector and hands PC, SP and the I flag back to the core.
module irq_vector_sequencer
  import irq_vector_sequencer_pkg::*;
#(
  parameter int          ADDR_W     = 16,
  parameter int          NUM_IRQ    = 4,
  parameter logic [7:0]  STACK_PAGE = 8'h01,
  parameter int          VEC_MODE   = 0,
  parameter logic [15:0] IRQ_TBL    = 16'hFFE0
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               instr_bound,
  input  logic               brk_req,
  input  logic               nmi_n,
  input  logic [NUM_IRQ-1:0] irq_req,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic [7:0]         p_in,
  input  logic [7:0]         sp_in,
  input  logic [7:0]         rd_data,
  output logic               busy,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [7:0]         mem_wr_data,
  output logic               mem_wr_en,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               pc_load,
  output logic [7:0]         sp_out,
  output logic               sp_load,
  output logic               set_i,
  output logic [NUM_IRQ-1:0] irq_ack
);

  localparam int CH_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  seq_state_e         state_q, state_d;
  entry_kind_e        kind_q, kind_d;
  logic [15:0]        vec_q, vec_d;
  logic [15:0]        pc_push_q, pc_push_d;
  logic [7:0]         p_push_q, p_push_d;
  logic [7:0]         sp_q, sp_d;
  logic [7:0]         vec_lo_q, vec_lo_d;
  logic [NUM_IRQ-1:0] ack_q, ack_d;
  logic               hijack_q, hijack_d;
  logic               nmi_q, nmi_pend_q, nmi_pend_d;
  logic               nmi_fall, nmi_clr;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [7:0]         wr_data_q, wr_data_d;
  logic               wr_en_q, wr_en_d;

  logic               irq_valid;
  logic [CH_W-1:0]    irq_idx;
  logic [NUM_IRQ-1:0] irq_onehot;
  logic [15:0]        irq_vec;
  logic               in_load;

  irq_prio_enc #(.N(NUM_IRQ), .IDX_W(CH_W)) u_prio (
    .req_i    (irq_req & irq_mask & {NUM_IRQ{~p_in[P_I]}}),
    .valid_o  (irq_valid),
    .idx_o    (irq_idx),
    .onehot_o (irq_onehot)
  );

  assign irq_vec  = (VEC_MODE != 0) ? IRQ_TBL + 16'({irq_idx, 1'b0}) : VEC_IRQ;
  assign nmi_fall = nmi_q & ~nmi_n;

  function automatic logic [ADDR_W-1:0] stack_addr(input logic [7:0] s);
    return ADDR_W'({STACK_PAGE, s});
  endfunction

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    vec_d     = vec_q;
    pc_push_d = pc_push_q;
    p_push_d  = p_push_q;
    sp_d      = sp_q;
    vec_lo_d  = vec_lo_q;
    ack_d     = ack_q;
    hijack_d  = hijack_q;
    nmi_clr   = 1'b0;

    case (state_q)
      RST_START: begin
        kind_d   = KIND_RST;
        vec_d    = VEC_RESET;
        sp_d     = sp_in;
        ack_d    = '0;
        hijack_d = 1'b0;
        state_d  = VEC_LO;
      end
      IDLE: begin
        if (instr_bound && (nmi_pend_q || brk_req || irq_valid)) begin
          pc_push_d = pc_in[15:0];
          sp_d      = sp_in;
          ack_d     = '0;
          hijack_d  = 1'b0;
          state_d   = PUSH_PCH;
          if (nmi_pend_q) begin
            kind_d   = KIND_NMI;
            vec_d    = VEC_NMI;
            p_push_d = push_status(p_in, 1'b0);
          end else if (brk_req) begin
            kind_d    = KIND_BRK;
            vec_d     = VEC_IRQ;
            pc_push_d = pc_in[15:0] + 16'd2;
            p_push_d  = push_status(p_in, 1'b1);
          end else begin
            kind_d   = KIND_IRQ;
            vec_d    = irq_vec;
            ack_d    = irq_onehot;
            p_push_d = push_status(p_in, 1'b0);
          end
        end
      end
      PUSH_PCH: state_d = PUSH_PCL;
      PUSH_PCL: state_d = PUSH_P;
      PUSH_P: begin
        // Last chance for a pending NMI to steal a maskable/BRK entry.
        if (kind_q != KIND_NMI && (nmi_pend_q || nmi_fall)) begin
          hijack_d = 1'b1;
          vec_d    = VEC_NMI;
        end
        state_d = VEC_LO;
      end
      VEC_LO: state_d = VEC_HI;
      VEC_HI: begin
        vec_lo_d = rd_data;
        state_d  = LOAD;
      end
      LOAD: begin
        nmi_clr = (kind_q == KIND_NMI) || hijack_q;
        state_d = IDLE;
      end
      default: state_d = RST_START;
    endcase

    nmi_pend_d = nmi_fall | (nmi_pend_q & ~nmi_clr);

    // Bus outputs are registered, so they are computed for the state being entered.
    mem_addr_d = '0;
    wr_data_d  = '0;
    wr_en_d    = 1'b0;
    case (state_d)
      PUSH_PCH: begin
        mem_addr_d = stack_addr(sp_d);
        wr_data_d  = pc_push_d[15:8];
        wr_en_d    = 1'b1;
      end
      PUSH_PCL: begin
        mem_addr_d = stack_addr(sp_d - 8'd1);
        wr_data_d  = pc_push_d[7:0];
        wr_en_d    = 1'b1;
      end
      PUSH_P: begin
        mem_addr_d = stack_addr(sp_d - 8'd2);
        wr_data_d  = p_push_d;
        wr_en_d    = 1'b1;
      end
      VEC_LO:  mem_addr_d = ADDR_W'(vec_d);
      VEC_HI:  mem_addr_d = ADDR_W'(vec_d + 16'd1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= RST_START;
      kind_q     <= KIND_RST;
      vec_q      <= '0;
      pc_push_q  <= '0;
      p_push_q   <= '0;
      sp_q       <= '0;
      vec_lo_q   <= '0;
      ack_q      <= '0;
      hijack_q   <= 1'b0;
      nmi_q      <= 1'b1;
      nmi_pend_q <= 1'b0;
      mem_addr_q <= '0;
      wr_data_q  <= '0;
      wr_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      vec_q      <= vec_d;
      pc_push_q  <= pc_push_d;
      p_push_q   <= p_push_d;
      sp_q       <= sp_d;
      vec_lo_q   <= vec_lo_d;
      ack_q      <= ack_d;
      hijack_q   <= hijack_d;
      nmi_q      <= nmi_n;
      nmi_pend_q <= nmi_pend_d;
      mem_addr_q <= mem_addr_d;
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
    end
  end

  assign in_load     = (state_q == LOAD);
  assign busy        = (state_q != IDLE);
  assign mem_addr    = mem_addr_q;
  assign mem_wr_data = wr_data_q;
  assign mem_wr_en   = wr_en_q;
  assign pc_load     = in_load;
  assign sp_load     = in_load;
  assign set_i       = in_load;
  // High vector byte arrives on rd_data in the LOAD cycle itself.
  assign pc_out      = in_load ? ADDR_W'({rd_data, vec_lo_q}) : '0;
  assign sp_out      = in_load ? sp_q - 8'd3 : 8'h00;
  assign irq_ack     = (in_load && kind_q == KIND_IRQ && !hijack_q) ? ack_q : '0;

endmodule

// File: tb/tb_irq_vector_sequencer.sv
// Drives two sequencers (VEC_MODE 0 and 1) with shared stimulus and checks every
// cycle against an entry-script model plus directed literal expectations.
module tb_irq_vector_sequencer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        instr_bound, brk_req, nmi_n;
  logic [3:0]  irq_req, irq_mask;
  logic [15:0] pc_in;
  logic [7:0]  p_in, sp_in;

  int n_vec = 0;
  int n_mis = 0;

  // Model: slot -1 = reset pending, 0 = idle, 1..6 = the six busy cycles of an entry.
  int          m_slot, m_kind, m_ch;   // kind: 0 reset, 1 nmi, 2 brk, 3 irq
  logic [15:0] m_pc;
  logic [7:0]  m_p, m_sp;
  logic [3:0]  m_ack;
  bit          m_hij, m_pend;
  logic        m_prev_nmi;

  logic [23:0] wlog[$];
  logic [15:0] rlog0[$], rlog1[$];

  always #5 clk = ~clk;

  function automatic logic [7:0] rom(input logic [15:0] a);
    if (a == 16'hFFFC) return 8'h34;
    if (a == 16'hFFFD) return 8'h12;
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    logic        busy_w, wen_w, pcl_w, spl_w, seti_w;
    logic [15:0] addr_w, pco_w;
    logic [7:0]  wd_w, spo_w, rd_q;
    logic [3:0]  ack_w;

    always @(posedge clk) rd_q <= rom(addr_w);

    irq_vector_sequencer #(
      .ADDR_W(16), .NUM_IRQ(4), .STACK_PAGE(8'h01), .VEC_MODE(gi), .IRQ_TBL(16'hFFE0)
    ) u_dut (
      .clk(clk), .resetn(resetn), .instr_bound(instr_bound), .brk_req(brk_req),
      .nmi_n(nmi_n), .irq_req(irq_req), .irq_mask(irq_mask), .pc_in(pc_in),
      .p_in(p_in), .sp_in(sp_in), .rd_data(rd_q), .busy(busy_w), .mem_addr(addr_w),
      .mem_wr_data(wd_w), .mem_wr_en(wen_w), .pc_out(pco_w), .pc_load(pcl_w),
      .sp_out(spo_w), .sp_load(spl_w), .set_i(seti_w), .irq_ack(ack_w)
    );
  end

  task automatic cmp(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s[%0d] t=%0t actual=%h required=%h", name, k, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_vec(input int mode);
    if (m_kind == 0) return 16'hFFFC;
    if (m_kind == 1 || m_hij) return 16'hFFFA;
    if (m_kind == 3 && mode == 1) return 16'hFFE0 + 16'(2 * m_ch);
    return 16'hFFFE;
  endfunction

  task automatic model_reset();
    m_slot = -1; m_pend = 0; m_prev_nmi = 1'b1; m_hij = 0; m_kind = 0; m_ack = 4'h0;
  endtask

  task automatic model_edge();
    bit fall, clr;
    int kind;
    fall = m_prev_nmi && !nmi_n;
    clr  = 0;
    case (m_slot)
      -1: begin m_slot = 4; m_kind = 0; m_sp = sp_in; m_hij = 0; m_ack = 4'h0; end
      0: begin
        kind = 0;
        if (instr_bound) begin
          if (m_pend) kind = 1;
          else if (brk_req) kind = 2;
          else if (!p_in[2] && (irq_req & irq_mask) != 4'h0) begin
            kind = 3;
            for (int c = 3; c >= 0; c--) if (irq_req[c] && irq_mask[c]) m_ch = c;
          end
        end
        if (kind != 0) begin
          m_kind = kind; m_slot = 1; m_sp = sp_in; m_hij = 0;
          m_pc   = (kind == 2) ? pc_in + 16'd2 : pc_in;
          m_p    = p_in | 8'h20;
          m_p[4] = (kind == 2);
          m_ack  = (kind == 3) ? 4'(1 << m_ch) : 4'h0;
        end
      end
      3: begin if (m_kind != 1 && (m_pend || fall)) m_hij = 1; m_slot = 4; end
      6: begin clr = (m_kind == 1) || m_hij; m_slot = 0; end
      default: m_slot++;
    endcase
    m_pend     = fall || (m_pend && !clr);
    m_prev_nmi = nmi_n;
  endtask

  task automatic compare_inst(input int k, input logic b, input logic [15:0] a, input logic [7:0] wd,
      input logic we, input logic [15:0] pco, input logic pcl, input logic [7:0] spo,
      input logic spl, input logic si, input logic [3:0] ack);
    logic [15:0] v, e_addr, e_pc;
    logic [7:0]  e_wd, e_sp;
    logic        e_we, e_ld;
    logic [3:0]  e_ack;
    v = exp_vec(k);
    e_addr = 16'h0; e_wd = 8'h0; e_we = 1'b0;
    case (m_slot)
      1: begin e_addr = {8'h01, m_sp};         e_wd = m_pc[15:8]; e_we = 1'b1; end
      2: begin e_addr = {8'h01, m_sp - 8'd1};  e_wd = m_pc[7:0];  e_we = 1'b1; end
      3: begin e_addr = {8'h01, m_sp - 8'd2};  e_wd = m_p;        e_we = 1'b1; end
      4: e_addr = v;
      5: e_addr = v + 16'd1;
      default: ;
    endcase
    e_ld  = (m_slot == 6);
    e_pc  = e_ld ? {rom(v + 16'd1), rom(v)} : 16'h0;
    e_sp  = e_ld ? m_sp - 8'd3 : 8'h0;
    e_ack = (e_ld && m_kind == 3 && !m_hij) ? m_ack : 4'h0;
    cmp("busy", k, b, m_slot != 0);
    cmp("mem_addr", k, a, e_addr);
    cmp("mem_wr_data", k, wd, e_wd);
    cmp("mem_wr_en", k, we, e_we);
    cmp("pc_out", k, pco, e_pc);
    cmp("pc_load", k, pcl, e_ld);
    cmp("sp_out", k, spo, e_sp);
    cmp("sp_load", k, spl, e_ld);
    cmp("set_i", k, si, e_ld);
    cmp("irq_ack", k, ack, e_ack);
    if (k == 0 && we) wlog.push_back({a, wd});
    if (b && !we && a != 16'h0) begin
      if (k == 0) rlog0.push_back(a); else rlog1.push_back(a);
    end
  endtask

  task automatic compare_all();
    compare_inst(0, g_dut[0].busy_w, g_dut[0].addr_w, g_dut[0].wd_w, g_dut[0].wen_w, g_dut[0].pco_w,
                 g_dut[0].pcl_w, g_dut[0].spo_w, g_dut[0].spl_w, g_dut[0].seti_w, g_dut[0].ack_w);
    compare_inst(1, g_dut[1].busy_w, g_dut[1].addr_w, g_dut[1].wd_w, g_dut[1].wen_w, g_dut[1].pco_w,
                 g_dut[1].pcl_w, g_dut[1].spo_w, g_dut[1].spl_w, g_dut[1].seti_w, g_dut[1].ack_w);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (resetn) model_edge(); else model_reset();
    @(negedge clk);
    compare_all();
  endtask

  task automatic clear_logs();
    wlog.delete(); rlog0.delete(); rlog1.delete();
  endtask

  task automatic async_reset(input int hold);
    resetn = 1'b0;
    model_reset();
    #1;
    compare_all();
    cmp("abort_wen", 0, g_dut[0].wen_w, 1'b0);
    repeat (hold) cycle();
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0; instr_bound = 1'b0; brk_req = 1'b0; nmi_n = 1'b1;
    irq_req = 4'h0; irq_mask = 4'h0; pc_in = 16'h0; p_in = 8'h0; sp_in = 8'hFF;
    model_reset();
    repeat (2) cycle();
    cmp("rst_busy", 0, g_dut[0].busy_w, 1'b1);
    cmp("rst_pc_load", 0, g_dut[0].pcl_w, 1'b0);

    // Reset vector fetch: LOAD on the 4th cycle after release.
    clear_logs();
    resetn = 1'b1;
    repeat (3) cycle();
    cmp("rst_pc_out", 0, g_dut[0].pco_w, 16'h1234);
    cmp("rst_set_i", 0, g_dut[0].seti_w, 1'b1);
    cmp("rst_sp_out", 0, g_dut[0].spo_w, 8'hFC);
    cmp("rst_no_writes", 0, wlog.size(), 0);
    cycle();

    // IRQ channel 2.
    clear_logs();
    instr_bound = 1'b1; irq_req = 4'b0100; irq_mask = 4'hF; p_in = 8'h81; pc_in = 16'hC000; sp_in = 8'hFF;
    cycle();
    instr_bound = 1'b0; irq_req = 4'h0;
    repeat (5) cycle();
    cmp("irq_w0", 0, wlog[0], 24'h01FFC0);
    cmp("irq_w1", 0, wlog[1], 24'h01FE00);
    cmp("irq_w2", 0, wlog[2], 24'h01FDA1);
    cmp("irq_vec", 0, rlog0[0], 16'hFFFE);
    cmp("irq_vec", 1, rlog1[0], 16'hFFE4);
    cmp("irq_sp_out", 0, g_dut[0].spo_w, 8'hFC);
    cmp("irq_ack", 0, g_dut[0].ack_w, 4'b0100);
    cycle();

    // BRK with stack wrap.
    clear_logs();
    instr_bound = 1'b1; brk_req = 1'b1; pc_in = 16'h0200; sp_in = 8'h00; p_in = 8'h00;
    cycle();
    instr_bound = 1'b0; brk_req = 1'b0;
    repeat (5) cycle();
    cmp("brk_w0", 0, wlog[0], 24'h010002);
    cmp("brk_w1", 0, wlog[1], 24'h01FF02);
    cmp("brk_w2", 0, wlog[2], 24'h01FE30);
    cmp("brk_sp_out", 0, g_dut[0].spo_w, 8'hFD);
    cmp("brk_vec", 1, rlog1[0], 16'hFFFE);
    cycle();

    // Masked by I, then NMI.
    clear_logs();
    irq_req = 4'b1010; p_in = 8'h04; instr_bound = 1'b1;
    repeat (3) cycle();
    cmp("imask_idle", 0, g_dut[0].busy_w, 1'b0);
    nmi_n = 1'b0;
    repeat (2) cycle();
    instr_bound = 1'b0;
    repeat (5) cycle();
    cmp("nmi_vec", 0, rlog0[0], 16'hFFFA);
    cmp("nmi_pc_load", 0, g_dut[0].pcl_w, 1'b1);
    cmp("nmi_ack", 1, g_dut[1].ack_w, 4'h0);
    nmi_n = 1'b1; instr_bound = 1'b1;
    repeat (3) cycle();
    cmp("nmi_cleared", 0, g_dut[0].busy_w, 1'b0);

    // IRQ hijacked by NMI falling in PUSH_PCL.
    clear_logs();
    irq_req = 4'b0001; p_in = 8'h00;
    cycle();
    irq_req = 4'h0; instr_bound = 1'b0;
    cycle();
    nmi_n = 1'b0;
    repeat (4) cycle();
    cmp("hij_vec_lo", 0, rlog0[0], 16'hFFFA);
    cmp("hij_vec_hi", 0, rlog0[1], 16'hFFFB);
    cmp("hij_ack", 0, g_dut[0].ack_w, 4'h0);
    nmi_n = 1'b1;
    cycle();
    instr_bound = 1'b1;
    repeat (3) cycle();
    cmp("hij_pend_clr", 0, g_dut[0].busy_w, 1'b0);

    // Table-vectored channel 3, then reset abort during PUSH_P.
    clear_logs();
    irq_req = 4'b1000;
    cycle();
    irq_req = 4'h0; instr_bound = 1'b0;
    repeat (5) cycle();
    cmp("tbl_vec_lo", 1, rlog1[0], 16'hFFE6);
    cmp("tbl_vec_hi", 1, rlog1[1], 16'hFFE7);
    cmp("tbl_ack", 1, g_dut[1].ack_w, 4'b1000);
    cycle();
    irq_req = 4'b0001; instr_bound = 1'b1;
    cycle();
    irq_req = 4'h0; instr_bound = 1'b0;
    repeat (2) cycle();
    clear_logs();
    async_reset(2);
    repeat (3) cycle();
    cmp("rerun_pc_out", 1, g_dut[1].pco_w, 16'h1234);
    cmp("rerun_no_writes", 0, wlog.size(), 0);
    cycle();

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        async_reset($urandom_range(1, 3));
      end else begin
        instr_bound = ($urandom_range(0, 4) < 3);
        brk_req     = ($urandom_range(0, 9) == 0);
        irq_req     = 4'($urandom);
        irq_mask    = 4'($urandom);
        p_in        = 8'($urandom);
        pc_in       = 16'($urandom);
        sp_in       = 8'($urandom);
        if (nmi_n && m_slot != 6 && $urandom_range(0, 39) == 0) nmi_n = 1'b0;
        else if (!nmi_n && $urandom_range(0, 3) == 0) nmi_n = 1'b1;
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
